// File: rtl/hms_display_scan_pkg.sv
// hms_disp_pkg: shared constants for the six-digit H:M:S multiplexed display.
// Holds the digit order, the active-low segment patterns and the field range limits.
package hms_disp_pkg;

   localparam int NUM_DIGITS = 6;

   // Digit slot order, least significant first; slot n drives an[n].
   typedef enum logic [2:0] {
      DIG_S1  = 3'd0,
      DIG_S10 = 3'd1,
      DIG_M1  = 3'd2,
      DIG_M10 = 3'd3,
      DIG_H1  = 3'd4,
      DIG_H10 = 3'd5
   } digit_e;

   // Field range limits; larger snapshot values are shown as dashes.
   localparam logic [4:0] H_MAX = 5'd23;
   localparam logic [5:0] M_MAX = 6'd59;
   localparam logic [5:0] S_MAX = 6'd59;

   // Segment patterns {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Split a 0..63 binary value into {tens, ones} BCD nibbles.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 6'd10);
      ones = 4'(v % 6'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/hms_display_scan_seg7_decode.sv
// seg7_decode: one BCD digit (plus dash override) to active-low 7-segment pattern.
// Non-decimal codes 10..15 render blank.
module seg7_decode
   import hms_disp_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dash,
   output logic [6:0] seg
);

   // Pattern lookup; the dash flag wins over the digit value.
   always_comb begin
      // NOTE: default assignment first so every path drives seg and no latch is inferred.
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/hms_display_scan.sv
// hms_display_scan: scans a captured H:M:S snapshot across six multiplexed
// 7-segment digits, one slot of SCAN_DIV clocks per digit.
// Optional feature macro: DP_BLINK_EN (colon-style decimal point blink on the
// minute-ones and hour-ones digits, driven by snapshot seconds bit 0).
module hms_display_scan
   import hms_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] H_reg,
   input  logic [5:0] M_reg,
   input  logic [5:0] S_reg,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       dp,
   output logic       frame_start
);

   localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] presc;
   digit_e      idx;
   logic [4:0]  snap_h;
   logic [5:0]  snap_m;
   logic [5:0]  snap_s;

   logic        slot_wrap;
   logic        frame_wrap;
   logic [7:0]  bcd_h;
   logic [7:0]  bcd_m;
   logic [7:0]  bcd_s;
   logic [3:0]  sel_bcd;
   logic        sel_dash;
   logic [6:0]  seg_next;

   assign slot_wrap  = (presc == PRESC_LAST);
   assign frame_wrap = slot_wrap && (idx == DIG_H10);

   // Prescaler, digit index and frame snapshot; snapshot updates only at frame wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc  <= '0;
         idx    <= DIG_S1;
         // NOTE: the snapshot is reset too, so the first frame after reset shows 00:00:00.
         snap_h <= '0;
         snap_m <= '0;
         snap_s <= '0;
      end else if (slot_wrap) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         presc <= '0;
         if (idx == DIG_H10) begin
            idx    <= DIG_S1;
            snap_h <= H_reg;
            snap_m <= M_reg;
            snap_s <= S_reg;
         end else begin
            idx <= digit_e'(idx + 3'd1);
         end
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // Select the BCD nibble and dash flag of the digit being scanned.
   always_comb begin
      bcd_h    = to_bcd({1'b0, snap_h});
      bcd_m    = to_bcd(snap_m);
      bcd_s    = to_bcd(snap_s);
      sel_bcd  = 4'd0;
      sel_dash = 1'b0;
      case (idx)
         DIG_S1:  begin sel_bcd = bcd_s[3:0]; sel_dash = (snap_s > S_MAX); end
         DIG_S10: begin sel_bcd = bcd_s[7:4]; sel_dash = (snap_s > S_MAX); end
         DIG_M1:  begin sel_bcd = bcd_m[3:0]; sel_dash = (snap_m > M_MAX); end
         DIG_M10: begin sel_bcd = bcd_m[7:4]; sel_dash = (snap_m > M_MAX); end
         DIG_H1:  begin sel_bcd = bcd_h[3:0]; sel_dash = (snap_h > H_MAX); end
         DIG_H10: begin sel_bcd = bcd_h[7:4]; sel_dash = (snap_h > H_MAX); end
         default: begin sel_bcd = 4'd0;       sel_dash = 1'b0;             end
      endcase
   end

   seg7_decode u_seg7_decode (
      .bcd  (sel_bcd),
      .dash (sel_dash),
      .seg  (seg_next)
   );

   // Registered display drive; digits are blanked on the first clock of each slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg         <= SEG_BLANK;
         an          <= '1;
         frame_start <= 1'b0;
      end else begin
         seg         <= seg_next;
         an          <= (presc == 16'd0) ? '1 : ~(6'b000001 << idx);
         frame_start <= frame_wrap;
      end
   end

`ifdef DP_BLINK_EN
   // Decimal point lit on minute-ones and hour-ones slots during even seconds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp <= 1'b1;
      end else begin
         dp <= !(((idx == DIG_M1) || (idx == DIG_H1)) && !snap_s[0]);
      end
   end
`else
   assign dp = 1'b1;
`endif

endmodule

// File: doc/hms_display_scan.md
HMS_DISPLAY_SCAN -- requirements
Module: hms_display_scan

Interface
REQ-001 SCAN_DIV, 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 H_reg  input  5  hours, binary; legal 0..23.
REQ-005 M_reg  input  6  minutes, binary; legal 0..59.
REQ-006 S_reg  input  6  seconds, binary; legal 0..59.
REQ-007 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 an  output  6  digit enables, active-low; an[0]=sec ones, an[1]=sec tens, an[2]=min ones, an[3]=min tens, an[4]=hr ones, an[5]=hr tens.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 frame_start  output  1  one-cycle pulse at snapshot capture.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index SHALL advance on the wrap edge, 0..5 then back to 0.
REQ-012 On the edge where index wraps 5->0, the block SHALL capture H_reg/M_reg/S_reg into a snapshot register; the displayed frame SHALL use only snapshot values (no tearing mid-frame).
REQ-013 frame_start SHALL be 1 for exactly the cycle after the capture edge, 0 otherwise.
REQ-014 Each field SHALL convert to two BCD digits (tens = value/10, ones = value%10); hours tens 0..2, min/sec tens 0..5.
REQ-015 Out-of-range snapshot field (H>23, M>59, S>59) SHALL show dash (only g lit, seg=7'b0111111) on both digits of that field; other fields unaffected.
REQ-016 seg, an, dp, frame_start SHALL be registered; outputs SHALL reflect index/prescaler state with exactly 1 cycle latency.
REQ-017 Blanking: while prescaler==0, an SHALL be 6'b111111 (anti-ghosting); otherwise exactly one an bit low, matching index.
REQ-018 Segment codes SHALL be standard 0-9 active-low (0=7'b1000000, 1=7'b1111001, 8=7'b0000000).
REQ-019 Input changes between captures SHALL have no effect on outputs.

Reset
REQ-020 On rst assertion, outputs SHALL immediately go to seg=7'h7F, an=6'h3F, dp=1, frame_start=0.
REQ-021 rst SHALL clear prescaler, index, snapshot (snapshot 00:00:00); first frame after release shows 00:00:00 until first capture.
REQ-022 rst asserted mid-slot SHALL abort the frame; no partial snapshot retained; release deasserts synchronously-safe (first count on next edge).

Configuration
REQ-023 Macro DP_BLINK_EN defined: dp SHALL be 0 during the an[2] and an[4] slots when snapshot S_reg[0]==0 (colon-style blink at 0.5 Hz), 1 otherwise.
REQ-024 DP_BLINK_EN undefined: dp SHALL be constant 1; no blink logic synthesised.

Structure
REQ-025 Package hms_disp_pkg SHALL hold NUM_DIGITS=6, segment pattern constants (digits 0-9, DASH, BLANK), and field range limits (23, 59).
REQ-026 Sub-module seg7_decode (4-bit BCD plus dash flag -> 7-bit active-low) SHALL be instantiated once, on the selected digit.

Verification (SCAN_DIV=4 in sim)
REQ-027 Reset, then H=12,M=34,S=56 held -> after first capture, slots an[0..5] show 6,5,4,3,2,1; seg for '6'=7'b0000010.
REQ-028 Slot timing -> an all-ones for 1 cycle, then single low bit for 3 cycles; frame_start period 24 cycles.
REQ-029 Change S 56->57 mid-frame -> current frame still shows 6; 7 appears only after next frame_start.
REQ-030 H=25, M=60, S=9 -> hour and minute digits show dash 7'b0111111; seconds show 9,0.
REQ-031 Assert rst mid-slot -> outputs 7'h7F/6'h3F/1/0 same cycle without clock edge; after release first frame shows 0,0,0,0,0,0.
REQ-032 DP_BLINK_EN defined, S=10 then S=11 -> dp=0 on an[2]/an[4] for S=10 frame, dp=1 throughout S=11 frame.
